// File: rtl/buck_phase_driver_pkg.sv
// Shared definitions for the buck converter phase driver.
//
// Holds the phase encoding used by the switch-timing FSM and the default
// timing parameters (all in clock cycles). The phase values are visible
// on the driver's 'phase' output, so they must stay fixed.
package buck_converter_async_params;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,  // both switches off, waiting for a charge request
      DT_HS = 3'd1,  // dead time before high-side turn-on
      HS_ON = 3'd2,  // high-side on, inductor energising
      DT_LS = 3'd3,  // dead time before low-side turn-on
      LS_ON = 3'd4   // low-side on, freewheeling
   } phase_t;

   localparam int DEAD_TIME = 4;    // both-off gap between gate transitions
   localparam int MIN_ON    = 8;    // minimum high-side on-time
   localparam int MAX_ON    = 200;  // high-side on-time limit
   localparam int OC_BLANK  = 3;    // OC ignored for this long after HS turn-on
   localparam int CNT_W     = 8;    // timer width

endpackage

// File: rtl/buck_phase_driver_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, clears both flops to 0
//   d     - asynchronous input level
//   q     - synchronised level, two clock edges behind d
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/buck_phase_driver.sv
// Buck converter phase driver: turns the controller's charge request and
// the over-current / zero-crossing comparator levels into non-overlapping
// high-side and low-side gate commands, with dead time, minimum and maximum
// on-time, OC blanking and DCM low-side cut-off.
//
// Ports:
//   clk, reset - block clock and synchronous active-high reset
//   enable     - synchronous driver enable; 0 forces both switches off
//   pwm_req    - async charge request (1 = energise inductor)
//   oc         - async over-current comparator
//   zc         - async zero-crossing comparator (inductor current <= 0)
//   hs_on      - registered high-side gate command
//   ls_on      - registered low-side gate command
//   oc_evt     - one-cycle pulse when OC ends a high-side pulse
//   maxon_evt  - one-cycle pulse when MAX_ON ends a high-side pulse
//   phase      - current FSM state (see phase_t)
module buck_phase_driver
   import buck_converter_async_params::*;
#(
   parameter int P_DEAD_TIME = DEAD_TIME,
   parameter int P_MIN_ON    = MIN_ON,
   parameter int P_MAX_ON    = MAX_ON,
   parameter int P_OC_BLANK  = OC_BLANK,
   parameter int P_CNT_W     = CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       pwm_req,
   input  logic       oc,
   input  logic       zc,
   output logic       hs_on,
   output logic       ls_on,
   output logic       oc_evt,
   output logic       maxon_evt,
   output logic [2:0] phase
);

   localparam logic [P_CNT_W-1:0] DT_LOAD   = P_CNT_W'(P_DEAD_TIME - 1);
   localparam logic [P_CNT_W-1:0] MIN_LAST  = P_CNT_W'(P_MIN_ON - 1);
   localparam logic [P_CNT_W-1:0] MAX_LAST  = P_CNT_W'(P_MAX_ON - 1);
   localparam logic [P_CNT_W-1:0] BLANK_END = P_CNT_W'(P_OC_BLANK);
   localparam logic [P_CNT_W-1:0] CNT_SAT   = {P_CNT_W{1'b1}};

   logic req_s, oc_s, zc_s;

   sync2 u_sync_req (.clk(clk), .reset(reset), .d(pwm_req), .q(req_s));
   sync2 u_sync_oc  (.clk(clk), .reset(reset), .d(oc),      .q(oc_s));
   sync2 u_sync_zc  (.clk(clk), .reset(reset), .d(zc),      .q(zc_s));

   phase_t             state, state_n;
   logic [P_CNT_W-1:0] timer, timer_n;    // dead-time countdown
   logic [P_CNT_W-1:0] on_cnt, on_cnt_n;  // cycles spent in HS_ON
   logic               oc_evt_n, maxon_evt_n;

   always_comb begin
      state_n     = state;
      timer_n     = timer;
      on_cnt_n    = on_cnt;
      oc_evt_n    = 1'b0;
      maxon_evt_n = 1'b0;

      if (!enable) begin
         state_n  = IDLE;
         timer_n  = '0;
         on_cnt_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_s) begin
                  state_n = DT_HS;
                  timer_n = DT_LOAD;
               end
            end
            DT_HS: begin
               if (timer == '0) begin
                  state_n  = HS_ON;
                  on_cnt_n = '0;
               end else begin
                  timer_n = timer - 1'b1;
               end
            end
            HS_ON: begin
               // Exit priority: OC, then MAX_ON, then request release.
               if (oc_s && (on_cnt >= BLANK_END)) begin
                  state_n  = DT_LS;
                  timer_n  = DT_LOAD;
                  oc_evt_n = 1'b1;
               end else if (on_cnt == MAX_LAST) begin
                  state_n     = DT_LS;
                  timer_n     = DT_LOAD;
                  maxon_evt_n = 1'b1;
               end else if (!req_s && (on_cnt >= MIN_LAST)) begin
                  state_n = DT_LS;
                  timer_n = DT_LOAD;
               end else if (on_cnt != CNT_SAT) begin
                  on_cnt_n = on_cnt + 1'b1;
               end
            end
            DT_LS: begin
               // The request is ignored here: a started pulse always
               // completes its low-side dead time.
               if (timer == '0) begin
                  state_n = LS_ON;
               end else begin
                  timer_n = timer - 1'b1;
               end
            end
            LS_ON: begin
               // A new request wins over ZC; OC blocks re-energising.
               if (req_s && !oc_s) begin
                  state_n = DT_HS;
                  timer_n = DT_LOAD;
               end else if (zc_s) begin
                  state_n = IDLE;
               end
            end
            default: begin
               state_n  = IDLE;
               timer_n  = '0;
               on_cnt_n = '0;
            end
         endcase
      end
   end

   // Gate commands are registered from the next state so they switch on the
   // same edge as the state register and carry no decode glitches.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         timer     <= '0;
         on_cnt    <= '0;
         hs_on     <= 1'b0;
         ls_on     <= 1'b0;
         oc_evt    <= 1'b0;
         maxon_evt <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         on_cnt    <= on_cnt_n;
         hs_on     <= (state_n == HS_ON);
         ls_on     <= (state_n == LS_ON);
         oc_evt    <= oc_evt_n;
         maxon_evt <= maxon_evt_n;
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_buck_phase_driver.sv
// Testbench for buck_phase_driver.
//
// Inputs are driven on the falling edge; outputs are compared on the falling
// edge against a cycle model that tracks the phase and the time spent in it.
module tb_buck_phase_driver;

   localparam int T_DT    = 4;
   localparam int T_MIN   = 8;
   localparam int T_MAX   = 200;
   localparam int T_BLANK = 3;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       pwm_req = 1'b0;
   logic       oc = 1'b0;
   logic       zc = 1'b0;
   logic       hs_on, ls_on, oc_evt, maxon_evt;
   logic [2:0] phase;

   always #5 clk = ~clk;

   buck_phase_driver dut (
      .clk(clk), .reset(reset), .enable(enable),
      .pwm_req(pwm_req), .oc(oc), .zc(zc),
      .hs_on(hs_on), .ls_on(ls_on),
      .oc_evt(oc_evt), .maxon_evt(maxon_evt),
      .phase(phase)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_oce = 0;
   int n_mxe = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_ph: 0 idle, 1 dead time before HS, 2 HS on, 3 dead time before LS,
   // 4 LS on. m_el counts cycles elapsed in the current timed phase.
   bit mv = 1'b0;
   int m_ph = 0;
   int m_el = 0;
   bit m_oce = 1'b0;
   bit m_mxe = 1'b0;
   bit rq[2], oq[2], zq[2];

   always @(posedge clk) begin
      bit sr, so, sz;
      sr = rq[1]; so = oq[1]; sz = zq[1];
      m_oce = 1'b0;
      m_mxe = 1'b0;
      if (reset) begin
         m_ph = 0; m_el = 0;
         rq[0] = 0; rq[1] = 0; oq[0] = 0; oq[1] = 0; zq[0] = 0; zq[1] = 0;
         mv = 1'b1;
      end else begin
         rq[1] = rq[0]; rq[0] = pwm_req;
         oq[1] = oq[0]; oq[0] = oc;
         zq[1] = zq[0]; zq[0] = zc;
         if (!enable) begin
            m_ph = 0; m_el = 0;
         end else begin
            case (m_ph)
               0: if (sr) begin m_ph = 1; m_el = 0; end
               1: if (m_el == T_DT - 1) begin m_ph = 2; m_el = 0; end else m_el++;
               2: begin
                  if (so && m_el >= T_BLANK) begin m_oce = 1; m_ph = 3; m_el = 0; end
                  else if (m_el == T_MAX - 1) begin m_mxe = 1; m_ph = 3; m_el = 0; end
                  else if (!sr && m_el >= T_MIN - 1) begin m_ph = 3; m_el = 0; end
                  else m_el++;
               end
               3: if (m_el == T_DT - 1) begin m_ph = 4; m_el = 0; end else m_el++;
               4: begin
                  if (sr && !so) begin m_ph = 1; m_el = 0; end
                  else if (sz) m_ph = 0;
               end
               default: m_ph = 0;
            endcase
         end
      end
   end

   // ---------------- scoreboard / compare ----------------
   always @(negedge clk) begin
      if (mv) begin
         check("hs_on", 32'(hs_on), 32'(m_ph == 2));
         check("ls_on", 32'(ls_on), 32'(m_ph == 4));
         check("phase", 32'(phase), 32'(m_ph));
         check("oc_evt", 32'(oc_evt), 32'(m_oce));
         check("maxon_evt", 32'(maxon_evt), 32'(m_mxe));
         check("no_overlap", 32'(hs_on & ls_on), 32'd0);
         if (oc_evt === 1'b1) n_oce++;
         if (maxon_evt === 1'b1) n_mxe++;
      end
   end

   // ---------------- driver tasks ----------------
   // Wait (bounded) for gate 'which' (0 = hs_on, 1 = ls_on) to reach 'lvl'.
   task automatic wait_lvl(input int which, input logic lvl, input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (((which == 0) ? hs_on : ls_on) === lvl) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         failures++;
         $display("FAIL wait_%s_%0d timeout after %0d cycles", (which == 0) ? "hs" : "ls", lvl, limit);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int t0, r, f, l, l2, x, m0, o0;

      ticks(3);
      check("reset_hs", 32'(hs_on), 32'd0);
      check("reset_ls", 32'(ls_on), 32'd0);
      check("reset_phase", 32'(phase), 32'd0);
      check("reset_evt", 32'(oc_evt | maxon_evt), 32'd0);
      reset = 1'b0;
      ticks(2);

      // Request held 20 cycles: 7-cycle latency, released after 16 HS cycles.
      pwm_req = 1'b1; t0 = cyc;
      wait_lvl(0, 1'b1, 20, r);
      check("req_latency", 32'(r - t0), 32'd7);
      ticks(t0 + 20 - cyc);
      pwm_req = 1'b0;
      wait_lvl(0, 1'b0, 50, f);
      check("hs_width_held", 32'(f - r), 32'd16);
      wait_lvl(1, 1'b1, 20, l);
      check("dt_hs_to_ls", 32'(l - f), 32'd4);
      ticks(5);
      check("ccm_freewheel", 32'(ls_on), 32'd1);

      // ZC in LS_ON ends the low-side pulse 3 cycles later.
      zc = 1'b1; x = cyc;
      wait_lvl(1, 1'b0, 10, l2);
      check("zc_latency", 32'(l2 - x), 32'd3);
      check("zc_phase_idle", 32'(phase), 32'd0);
      zc = 1'b0;
      ticks(3);

      // One-cycle request gives a MIN_ON pulse.
      pwm_req = 1'b1;
      @(negedge clk);
      pwm_req = 1'b0;
      wait_lvl(0, 1'b1, 20, r);
      wait_lvl(0, 1'b0, 30, f);
      check("hs_width_min", 32'(f - r), 32'd8);
      wait_lvl(1, 1'b1, 20, l);
      check("dt_hs_to_ls_min", 32'(l - f), 32'd4);

      // ZC and request together in LS_ON: request wins.
      ticks(2);
      zc = 1'b1; pwm_req = 1'b1; x = cyc;
      ticks(3);
      check("req_over_zc_phase", 32'(phase), 32'd1);
      check("req_over_zc_ls", 32'(ls_on), 32'd0);
      pwm_req = 1'b0;
      ticks(30);
      check("zc_back_to_idle", 32'(phase), 32'd0);
      zc = 1'b0;
      ticks(3);

      // OC right at HS turn-on: blanked, then ends the pulse at on_cnt = 3.
      pwm_req = 1'b1;
      wait_lvl(0, 1'b1, 20, r);
      oc = 1'b1; o0 = n_oce;
      wait_lvl(0, 1'b0, 20, f);
      check("hs_width_oc", 32'(f - r), 32'd4);
      wait_lvl(1, 1'b1, 20, l);
      check("dt_oc_to_ls", 32'(l - f), 32'd4);
      ticks(15);
      check("oc_holds_ls", 32'(ls_on), 32'd1);
      check("oc_evt_once", 32'(n_oce - o0), 32'd1);
      oc = 1'b0; x = cyc;
      wait_lvl(1, 1'b0, 10, l2);
      check("oc_release_latency", 32'(l2 - x), 32'd3);

      // Request held: MAX_ON pulses with CCM cycling.
      m0 = n_mxe;
      wait_lvl(0, 1'b1, 20, r);
      wait_lvl(0, 1'b0, 250, f);
      check("hs_width_max", 32'(f - r), 32'd200);
      wait_lvl(1, 1'b1, 20, l);
      check("dt_max_to_ls", 32'(l - f), 32'd4);
      check("maxon_evt_once", 32'(n_mxe - m0), 32'd1);
      wait_lvl(1, 1'b0, 10, l2);
      check("ls_single_cycle", 32'(l2 - l), 32'd1);
      wait_lvl(0, 1'b1, 20, r);
      check("dt_ls_to_hs", 32'(r - l2), 32'd4);
      wait_lvl(0, 1'b0, 250, f);
      check("hs_width_max2", 32'(f - r), 32'd200);

      // enable=0 mid HS_ON.
      wait_lvl(0, 1'b1, 20, r);
      ticks(10);
      enable = 1'b0;
      @(negedge clk);
      check("dis_hs", 32'(hs_on), 32'd0);
      check("dis_ls", 32'(ls_on), 32'd0);
      check("dis_phase", 32'(phase), 32'd0);
      ticks(3);
      enable = 1'b1; x = cyc;
      wait_lvl(0, 1'b1, 20, r);
      check("reenable_latency", 32'(r - x), 32'd5);

      // reset mid HS_ON.
      ticks(10);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_hs", 32'(hs_on), 32'd0);
      check("rst_mid_ls", 32'(ls_on), 32'd0);
      check("rst_mid_phase", 32'(phase), 32'd0);
      reset = 1'b0; x = cyc;
      wait_lvl(0, 1'b1, 20, r);
      check("rst_release_latency", 32'(r - x), 32'd7);
      pwm_req = 1'b0;
      ticks(30);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
